bel_fft_mem_responder: RTL and testbench

Avalon-MM slave sample memory that answers the FFT core's pipelined master port (m_* read/write with waitrequest and readdatavalid). It holds the in-place FFT working buffer. A second single-word host port lets the audio capture path load samples and the visualizer read back bins. Contention between the two ports is resolved cycle by cycle with alternating priority.

---
 rtl/bel_fft_mem_responder_if.sv | 52 +++++
 rtl/bel_fft_mem_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_bel_fft_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bel_fft_mem_responder_if.sv
// ---------------------------------------------------------------------------
// bel_fft_mem_responder_if
//
// Bus bundle for bel_fft_mem_responder: the FFT core's pipelined Avalon-MM
// master port (s_*) and the single-word host port (h_*).
//
// Parameters:
//   DWIDTH      data word width
//   AWIDTH      FFT-side byte address width
//   DEPTH_LOG2  log2 of memory depth in words (host address width)
//
// Modports:
//   slave   the memory responder (accepts requests, drives waitrequest/returns)
//   master  the requesting side (FFT core + host, or a testbench)
// ---------------------------------------------------------------------------
interface bel_fft_mem_responder_if #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 32,
    parameter int DEPTH_LOG2 = 8
);
    // FFT-side port
    logic [AWIDTH-1:0]     s_address;
    logic                  s_read;
    logic                  s_write;
    logic [DWIDTH-1:0]     s_writedata;
    logic                  s_waitrequest;
    logic [DWIDTH-1:0]     s_readdata;
    logic                  s_readdatavalid;

    // Host-side port
    logic [DEPTH_LOG2-1:0] h_address;
    logic                  h_read;
    logic                  h_write;
    logic [DWIDTH-1:0]     h_writedata;
    logic                  h_waitrequest;
    logic [DWIDTH-1:0]     h_readdata;
    logic                  h_readdatavalid;

    modport slave (
        input  s_address, s_read, s_write, s_writedata,
        output s_waitrequest, s_readdata, s_readdatavalid,
        input  h_address, h_read, h_write, h_writedata,
        output h_waitrequest, h_readdata, h_readdatavalid
    );

    modport master (
        output s_address, s_read, s_write, s_writedata,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        output h_address, h_read, h_write, h_writedata,
        input  h_waitrequest, h_readdata, h_readdatavalid
    );
endinterface

// File: rtl/bel_fft_mem_responder.sv
// ---------------------------------------------------------------------------
// bel_fft_mem_responder
//
// Avalon-MM slave sample memory holding the in-place FFT working buffer.
// The FFT core reaches it through a pipelined read/write port with
// waitrequest/readdatavalid; a host port lets the capture path load samples
// and the visualizer read bins back. A single-port RAM serves one access per
// cycle; conflicts between the ports are resolved with alternating priority.
//
// Parameters:
//   DWIDTH      data word width (32)
//   AWIDTH      FFT-side byte address width (32)
//   DEPTH_LOG2  log2 of memory depth in words (8 -> 256 words)
//   RD_LAT      FFT-side read latency in cycles, legal range 1..4 (2)
//
// Ports:
//   clk_i   clock, all logic on the rising edge
//   rst_i   synchronous active-high reset
//   bus     bel_fft_mem_responder_if.slave
//             s_* : FFT byte-addressed port, word = s_address[DEPTH_LOG2+1:2]
//             h_* : host word-addressed port, fixed read latency 1
//   err_o   sticky out-of-range error flag
//
// Optional feature (macro BEL_FFT_MEM_RANGE_CHK_EN):
//   When defined, FFT accesses with nonzero address bits above DEPTH_LOG2+1
//   are accepted but writes are dropped, reads return 0, and err_o latches
//   high until reset. When undefined, upper bits alias into the RAM and
//   err_o is tied low.
// ---------------------------------------------------------------------------
module bel_fft_mem_responder #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    bel_fft_mem_responder_if.slave  bus,
    output logic                    err_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic                  w_s_req;
    logic                  w_h_req;
    logic                  w_host_wins;
    logic                  w_fft_wins;
    logic                  w_s_acc;
    logic                  w_h_acc;
    logic                  w_s_wr;
    logic                  w_s_rd;
    logic                  w_h_wr;
    logic                  w_h_rd;
    logic [DEPTH_LOG2-1:0] w_s_word;
    logic                  w_s_oor;
    logic                  w_unused_addr_bits;

    assign w_s_req  = bus.s_read | bus.s_write;
    assign w_h_req  = bus.h_read | bus.h_write;
    assign w_s_word = bus.s_address[DEPTH_LOG2+1:2];

    // ---------------------------------------------------------------------
    // Arbitration state
    // Only "FFT port lost last conflict" changes behaviour (it flips the
    // default host priority), so NONE and H share encoding 0 and S is 1.
    // ---------------------------------------------------------------------
    logic r_s_stalled;
    logic w_s_stalled_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s_stalled <= 1'b0;
        end else begin
            r_s_stalled <= w_s_stalled_next;
        end
    end

    always_comb begin
        w_s_stalled_next = r_s_stalled;
        // Only a real conflict records a loser; lone requests leave it alone.
        if (w_s_req && w_h_req) begin
            w_s_stalled_next = w_host_wins;
        end
    end

    always_comb begin
        w_host_wins = w_h_req & (~w_s_req | ~r_s_stalled);
        w_fft_wins  = w_s_req & ~w_host_wins;

        bus.s_waitrequest = rst_i | (w_s_req & w_host_wins);
        bus.h_waitrequest = ~rst_i & w_h_req & w_fft_wins;

        // Nothing is accepted while reset is held.
        w_s_acc = w_fft_wins  & ~rst_i;
        w_h_acc = w_host_wins & ~rst_i;

        // Read and write together means write only.
        w_s_wr = w_s_acc & bus.s_write;
        w_s_rd = w_s_acc & ~bus.s_write;
        w_h_wr = w_h_acc & bus.h_write;
        w_h_rd = w_h_acc & ~bus.h_write;
    end

    // ---------------------------------------------------------------------
    // Single-port RAM, one access per cycle, registered read
    // ---------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] w_ram_addr;
    logic [DWIDTH-1:0]     w_ram_wdata;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [DWIDTH-1:0]     r_mem [DEPTH];
    logic [DWIDTH-1:0]     r_ram_q;

    always_comb begin
        w_ram_addr  = w_s_acc ? w_s_word        : bus.h_address;
        w_ram_wdata = w_s_acc ? bus.s_writedata : bus.h_writedata;
        w_ram_we    = (w_s_wr & ~w_s_oor) | w_h_wr;
        w_ram_re    = w_s_rd | w_h_rd;
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
        if (w_ram_re) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    // ---------------------------------------------------------------------
    // Range check
    // ---------------------------------------------------------------------
    logic              r_s_vld1;
    logic [DWIDTH-1:0] w_s_stage1_data;

`ifdef BEL_FFT_MEM_RANGE_CHK_EN
    logic r_s_oor1;
    logic r_err;

    assign w_s_oor            = |bus.s_address[AWIDTH-1:DEPTH_LOG2+2];
    assign w_unused_addr_bits = ^bus.s_address[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s_oor1 <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_s_oor1 <= w_s_rd & w_s_oor;
            if (w_s_acc && w_s_oor) begin
                r_err <= 1'b1;
            end
        end
    end

    // RAM output for an out-of-range read is meaningless; force it to 0.
    assign w_s_stage1_data = r_s_oor1 ? '0 : r_ram_q;
    assign err_o           = r_err;
`else
    assign w_s_oor            = 1'b0;
    assign w_unused_addr_bits = ^{bus.s_address[AWIDTH-1:DEPTH_LOG2+2],
                                  bus.s_address[1:0]};
    assign w_s_stage1_data    = r_ram_q;
    assign err_o              = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FFT read return pipeline
    // Stage 1 is the RAM output register itself; stages 2..RD_LAT delay the
    // valid and data together so returns stay in order at one per cycle.
    // ---------------------------------------------------------------------
    logic              w_s_tail_vld;
    logic [DWIDTH-1:0] w_s_tail_data;
    logic              w_s_out_vld;
    logic [DWIDTH-1:0] r_s_hold;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s_vld1 <= 1'b0;
        end else begin
            r_s_vld1 <= w_s_rd;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign w_s_tail_vld  = r_s_vld1;
            assign w_s_tail_data = w_s_stage1_data;
        end else begin : g_latn
            for (genvar gi = 2; gi <= RD_LAT; gi++) begin : g_stage
                logic              r_vld;
                logic [DWIDTH-1:0] r_q;
                if (gi == 2) begin : g_head
                    always_ff @(posedge clk_i) begin
                        if (rst_i) begin
                            r_vld <= 1'b0;
                        end else begin
                            r_vld <= r_s_vld1;
                        end
                        r_q <= w_s_stage1_data;
                    end
                end else begin : g_body
                    always_ff @(posedge clk_i) begin
                        if (rst_i) begin
                            r_vld <= 1'b0;
                        end else begin
                            r_vld <= g_stage[gi-1].r_vld;
                        end
                        r_q <= g_stage[gi-1].r_q;
                    end
                end
            end
            assign w_s_tail_vld  = g_stage[RD_LAT].r_vld;
            assign w_s_tail_data = g_stage[RD_LAT].r_q;
        end
    endgenerate

    // Gating with rst_i kills a return that would land in the very cycle
    // reset rises, before the pipeline registers have been cleared.
    assign w_s_out_vld = w_s_tail_vld & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s_hold <= '0;
        end else if (w_s_out_vld) begin
            r_s_hold <= w_s_tail_data;
        end
    end

    assign bus.s_readdatavalid = w_s_out_vld;
    assign bus.s_readdata      = w_s_out_vld ? w_s_tail_data : r_s_hold;

    // ---------------------------------------------------------------------
    // Host read return, fixed latency 1
    // ---------------------------------------------------------------------
    logic              r_h_vld;
    logic              w_h_out_vld;
    logic [DWIDTH-1:0] r_h_hold;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_h_vld <= 1'b0;
        end else begin
            r_h_vld <= w_h_rd;
        end
    end

    assign w_h_out_vld = r_h_vld & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_h_hold <= '0;
        end else if (w_h_out_vld) begin
            r_h_hold <= r_ram_q;
        end
    end

    assign bus.h_readdatavalid = w_h_out_vld;
    assign bus.h_readdata      = w_h_out_vld ? r_ram_q : r_h_hold;

endmodule

// File: tb/tb_bel_fft_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_bel_fft_mem_responder
//
// Self-checking bench for bel_fft_mem_responder. Expected read returns are
// pushed to per-port queues when a read is accepted and popped when the DUT
// returns data. A small arbitration and memory model predicts waitrequest,
// acceptance, data and err_o every cycle.
// ---------------------------------------------------------------------------
module tb_bel_fft_mem_responder;
    localparam int DWIDTH     = 32;
    localparam int AWIDTH     = 32;
    localparam int DEPTH_LOG2 = 8;
    localparam int RD_LAT     = 2;

`ifdef BEL_FFT_MEM_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    logic err;

    int   total;
    int   bad;
    int   cyc;
    logic m_sst;
    logic m_err;
    logic obs_s_wait;
    logic [31:0] model [256];
    exp_t s_q [$];
    exp_t h_q [$];

    bel_fft_mem_responder_if #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH_LOG2(DEPTH_LOG2)
    ) bus ();

    bel_fft_mem_responder #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.s_address   = '0;
        bus.s_read      = 1'b0;
        bus.s_write     = 1'b0;
        bus.s_writedata = '0;
        bus.h_address   = '0;
        bus.h_read      = 1'b0;
        bus.h_write     = 1'b0;
        bus.h_writedata = '0;
    endtask

    // One clock cycle: check this cycle's outputs, predict acceptance, clock.
    task automatic step();
        logic s_req, h_req, hw, exp_sw, exp_hw, s_acc, h_acc, oor;
        logic [7:0] sidx;
        exp_t e;
        #1;
        if (rst) begin
            s_q.delete();
            h_q.delete();
        end
        while (s_q.size() > 0 && s_q[0].due < cyc) begin
            e = s_q.pop_front();
            total++; bad++;
            $display("FAIL s_missing_return cyc=%0d got no valid expected data=%h due=%0d", cyc, e.data, e.due);
        end
        while (h_q.size() > 0 && h_q[0].due < cyc) begin
            e = h_q.pop_front();
            total++; bad++;
            $display("FAIL h_missing_return cyc=%0d got no valid expected data=%h due=%0d", cyc, e.data, e.due);
        end
        if (bus.s_readdatavalid !== 1'b0) begin
            total++;
            if (s_q.size() == 0) begin
                bad++;
                $display("FAIL s_unexpected_valid cyc=%0d got valid=%b data=%h expected no return", cyc, bus.s_readdatavalid, bus.s_readdata);
            end else begin
                e = s_q.pop_front();
                if (bus.s_readdata !== e.data || cyc != e.due) begin
                    bad++;
                    $display("FAIL s_return cyc=%0d got data=%h expected data=%h at cyc=%0d", cyc, bus.s_readdata, e.data, e.due);
                end else begin
                    $display("cyc=%0d s return data=%h", cyc, bus.s_readdata);
                end
            end
        end
        if (bus.h_readdatavalid !== 1'b0) begin
            total++;
            if (h_q.size() == 0) begin
                bad++;
                $display("FAIL h_unexpected_valid cyc=%0d got valid=%b data=%h expected no return", cyc, bus.h_readdatavalid, bus.h_readdata);
            end else begin
                e = h_q.pop_front();
                if (bus.h_readdata !== e.data || cyc != e.due) begin
                    bad++;
                    $display("FAIL h_return cyc=%0d got data=%h expected data=%h at cyc=%0d", cyc, bus.h_readdata, e.data, e.due);
                end else begin
                    $display("cyc=%0d h return data=%h", cyc, bus.h_readdata);
                end
            end
        end
        total++;
        if (err !== m_err) begin
            bad++;
            $display("FAIL err_o cyc=%0d got %b expected %b", cyc, err, m_err);
        end

        s_req = bus.s_read | bus.s_write;
        h_req = bus.h_read | bus.h_write;
        if (rst) begin
            hw = 1'b0; exp_sw = 1'b1; exp_hw = 1'b0; s_acc = 1'b0; h_acc = 1'b0;
        end else begin
            hw     = h_req & (!s_req | !m_sst);
            exp_sw = s_req & hw;
            exp_hw = h_req & !hw;
            s_acc  = s_req & !exp_sw;
            h_acc  = h_req & !exp_hw;
        end
        obs_s_wait = bus.s_waitrequest;
        total++;
        if (bus.s_waitrequest !== exp_sw) begin
            bad++;
            $display("FAIL s_waitrequest cyc=%0d got %b expected %b", cyc, bus.s_waitrequest, exp_sw);
        end
        total++;
        if (bus.h_waitrequest !== exp_hw) begin
            bad++;
            $display("FAIL h_waitrequest cyc=%0d got %b expected %b", cyc, bus.h_waitrequest, exp_hw);
        end

        oor  = RCHK && (bus.s_address[31:10] != 22'd0);
        sidx = bus.s_address[9:2];
        if (s_acc) begin
            if (bus.s_write) begin
                if (!oor) model[sidx] = bus.s_writedata;
                $display("cyc=%0d s write addr=%h data=%h", cyc, bus.s_address, bus.s_writedata);
            end else begin
                e.data = oor ? 32'h0 : model[sidx];
                e.due  = cyc + RD_LAT;
                s_q.push_back(e);
                $display("cyc=%0d s read addr=%h", cyc, bus.s_address);
            end
        end
        if (h_acc) begin
            if (bus.h_write) begin
                model[bus.h_address] = bus.h_writedata;
                $display("cyc=%0d h write idx=%0d data=%h", cyc, bus.h_address, bus.h_writedata);
            end else begin
                e.data = model[bus.h_address];
                e.due  = cyc + 1;
                h_q.push_back(e);
                $display("cyc=%0d h read idx=%0d", cyc, bus.h_address);
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_sst = 1'b0;
            m_err = 1'b0;
        end else begin
            if (s_req && h_req) m_sst = hw;
            if (s_acc && oor) m_err = 1'b1;
        end
    endtask

    task automatic fft_write(input logic [31:0] addr, input logic [31:0] data);
        bus.s_address = addr; bus.s_writedata = data;
        bus.s_write = 1'b1; bus.s_read = 1'b0;
        step();
        bus.s_write = 1'b0;
    endtask

    task automatic fft_read(input logic [31:0] addr);
        bus.s_address = addr; bus.s_read = 1'b1; bus.s_write = 1'b0;
        step();
        bus.s_read = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 12 && (s_q.size() > 0 || h_q.size() > 0); i++) step();
        total++;
        if (s_q.size() != 0 || h_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d/%0d pending returns expected 0/0", s_q.size(), h_q.size());
            s_q.delete();
            h_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (3) step();
        rst = 1'b0;
        #1;
        total++;
        if (bus.s_readdatavalid !== 1'b0 || bus.s_readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_s_outputs got valid=%b data=%h expected 0/0", bus.s_readdatavalid, bus.s_readdata);
        end
        total++;
        if (bus.h_readdatavalid !== 1'b0 || bus.h_readdata !== 32'h0 || bus.h_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL reset_h_outputs got valid=%b data=%h wait=%b expected 0/0/0", bus.h_readdatavalid, bus.h_readdata, bus.h_waitrequest);
        end
        total++;
        if (err !== 1'b0 || bus.s_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL reset_err_wait got err=%b s_wait=%b expected 0/0", err, bus.s_waitrequest);
        end
    endtask

    task automatic test_fill_readback();
        for (int i = 0; i < 256; i++) fft_write(i * 4, i);
        for (int i = 0; i < 256; i++) begin
            bus.s_address = i * 4; bus.s_read = 1'b1;
            step();
        end
        drain();
    endtask

    task automatic test_contention();
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.s_address = 32'h40; bus.s_read = 1'b1;
        bus.h_address = 8'd17;  bus.h_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (obs_s_wait !== pat[i]) begin
                bad++;
                $display("FAIL contention_pattern step=%0d got s_wait=%b expected %b", i, obs_s_wait, pat[i]);
            end
        end
        drain();
    endtask

    task automatic test_raw_cross();
        bus.h_address = 8'd5; bus.h_writedata = 32'hCAFEF00D; bus.h_write = 1'b1;
        step();
        bus.h_write = 1'b0;
        fft_read(32'h14);
        drain();
    endtask

    task automatic test_rw_simul();
        bus.s_address = 32'h08; bus.s_writedata = 32'h12345678;
        bus.s_read = 1'b1; bus.s_write = 1'b1;
        step();
        idle();
        repeat (RD_LAT + 2) step();
        fft_read(32'h08);
        drain();
    endtask

    task automatic test_reset_midflight();
        fft_read(32'h0C);
        fft_read(32'h10);
        rst = 1'b1;
        idle();
        repeat (2) step();
        rst = 1'b0;
        repeat (RD_LAT + 2) step();
        fft_read(32'h0C);
        fft_read(32'h10);
        fft_read(32'h08);
        drain();
    endtask

    task automatic test_range();
        fft_write(32'h400, 32'hFFFFFFFF);
        fft_read(32'h400);
        fft_read(32'h000);
        drain();
        total++;
        if (err !== RCHK) begin
            bad++;
            $display("FAIL range_err_sticky got err=%b expected %b", err, RCHK);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL range_err_cleared got err=%b expected 0", err);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        m_sst = 1'b0; m_err = 1'b0; obs_s_wait = 1'b0;
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_fill_readback();
        test_contention();
        test_raw_cross();
        test_rw_simul();
        test_reset_midflight();
        test_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
